arr_check_seq: RTL and testbench

Sequencer directly upstream of the per-lane `arr` checker instances. It walks NLANES lanes in order. For each lane it:
- drives a deterministic pattern onto that lane's sig/rfr pair,
- raises check,
- waits for the lane to clear check, and counts any mismatch the lane reports.

It replaces hand-written VPI pokes with an RTL stimulus source, so regressions run without a C monitor.

---
 rtl/arr_check_seq.sv | 162 ++++++++++++++++
 tb/tb_arr_check_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arr_check_seq.sv
// Stimulus sequencer walking NLANES arr checker lanes with sig/rfr patterns.
// Optional ARR_CHECK_SEQ_TIMEOUT_EN adds a WAIT timeout and timeout_o.
module arr_check_seq #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NLANES = 8,
  parameter logic [31:0] SEED   = 32'h1,
  parameter logic [31:0] STEP   = 32'h9E3779B9
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic                       start_i,
  input  logic                       inject_en_i,
  input  logic [$clog2(NLANES):0]    inject_lane_i,
  output logic [$clog2(NLANES):0]    lane_o,
  output logic [WIDTH-1:0]           sig_o,
  output logic [WIDTH-1:0]           rfr_o,
  output logic                       check_o,
  input  logic                       check_i,
  input  logic                       mismatch_i,
  output logic                       busy_o,
  output logic                       done_o,
`ifdef ARR_CHECK_SEQ_TIMEOUT_EN
  output logic                       timeout_o,
`endif
  output logic [7:0]                 err_count_o
);

  localparam int unsigned LW = $clog2(NLANES) + 1;
  localparam logic [WIDTH-1:0] P_SEED = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] P_STEP = WIDTH'(STEP);
  localparam logic [LW-1:0]    P_LAST = LW'(NLANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PULSE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_pat;
  logic            r_inj_en;
  logic [LW-1:0]   r_inj_lane;
  logic            r_first;
  logic            r_counted;

  logic [LW-1:0]    w_nxt_lane;
  logic [WIDTH-1:0] w_nxt_pat;
  logic             w_last;
  logic             w_flip0;
  logic             w_flip;
  logic             w_exit;
  logic             w_tmo;
  logic             w_adv;
  logic             w_inc;
  logic [7:0]       w_err_sat;

  assign w_nxt_lane = lane_o + LW'(1);
  assign w_nxt_pat  = r_pat + P_STEP;
  assign w_last     = (lane_o == P_LAST);
  assign w_flip0    = inject_en_i && (inject_lane_i == '0);
  assign w_flip     = r_inj_en && (r_inj_lane == w_nxt_lane);
  // Exit needs a low readback, but never on the first WAIT cycle
  assign w_exit     = !check_i && !r_first;

`ifdef ARR_CHECK_SEQ_TIMEOUT_EN
  logic [15:0] r_wcnt;
  assign w_tmo = check_i && (r_wcnt == 16'hFFFF);
`else
  assign w_tmo = 1'b0;
`endif

  assign w_adv     = w_exit || w_tmo;
  assign w_inc     = !r_counted && ((check_i && mismatch_i) || w_tmo);
  assign w_err_sat = (err_count_o == 8'hFF) ? err_count_o
                                            : err_count_o + 8'd1;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state     <= S_IDLE;
      r_pat       <= '0;
      r_inj_en    <= 1'b0;
      r_inj_lane  <= '0;
      r_first     <= 1'b0;
      r_counted   <= 1'b0;
      lane_o      <= '0;
      sig_o       <= '0;
      rfr_o       <= '0;
      check_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_count_o <= '0;
`ifdef ARR_CHECK_SEQ_TIMEOUT_EN
      r_wcnt      <= '0;
      timeout_o   <= 1'b0;
`endif
    end else begin
      check_o <= 1'b0;
      done_o  <= 1'b0;
`ifdef ARR_CHECK_SEQ_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_inj_en    <= inject_en_i;
            r_inj_lane  <= inject_lane_i;
            lane_o      <= '0;
            r_pat       <= P_SEED;
            sig_o       <= P_SEED;
            rfr_o       <= P_SEED ^ WIDTH'(w_flip0);
            err_count_o <= '0;
            busy_o      <= 1'b1;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          check_o <= 1'b1;
          r_state <= S_PULSE;
        end
        S_PULSE: begin
          r_first   <= 1'b1;
          r_counted <= 1'b0;
`ifdef ARR_CHECK_SEQ_TIMEOUT_EN
          r_wcnt    <= '0;
`endif
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          r_first <= 1'b0;
`ifdef ARR_CHECK_SEQ_TIMEOUT_EN
          r_wcnt    <= r_wcnt + 16'd1;
          timeout_o <= w_tmo;
`endif
          if (w_inc) begin
            err_count_o <= w_err_sat;
            r_counted   <= 1'b1;
          end
          if (w_adv) begin
            if (w_last) begin
              done_o  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              lane_o  <= w_nxt_lane;
              r_pat   <= w_nxt_pat;
              sig_o   <= w_nxt_pat;
              rfr_o   <= w_nxt_pat ^ WIDTH'(w_flip);
              r_state <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arr_check_seq.sv
// Directed bench for arr_check_seq with a behavioural lane model.
// Define ARR_CHECK_SEQ_TIMEOUT_EN to include the timeout scenario.
module tb_arr_check_seq;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset_l = 1'b0;
  logic          start_i = 1'b0;
  logic          inject_en_i = 1'b0;
  logic [LW-1:0] inject_lane_i = '0;
  logic [LW-1:0] lane_o;
  logic [W-1:0]  sig_o;
  logic [W-1:0]  rfr_o;
  logic          check_o;
  logic          check_i;
  logic          mismatch_i;
  logic          busy_o;
  logic          done_o;
  logic [7:0]    err_count_o;
`ifdef ARR_CHECK_SEQ_TIMEOUT_EN
  logic          timeout_o;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  arr_check_seq #(
    .WIDTH (W),
    .NLANES(N),
    .SEED  (32'h1),
    .STEP  (32'h9E3779B9)
  ) dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .start_i      (start_i),
    .inject_en_i  (inject_en_i),
    .inject_lane_i(inject_lane_i),
    .lane_o       (lane_o),
    .sig_o        (sig_o),
    .rfr_o        (rfr_o),
    .check_o      (check_o),
    .check_i      (check_i),
    .mismatch_i   (mismatch_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
`ifdef ARR_CHECK_SEQ_TIMEOUT_EN
    .timeout_o    (timeout_o),
`endif
    .err_count_o  (err_count_o)
  );

  always #5 clk = ~clk;

  // Lane model: check register set by check_o, self-clears after a hold
  logic r_chk;
  int   r_cnt;
  logic long_l2  = 1'b0;
  logic force_mm = 1'b0;
  logic stuck_l0 = 1'b0;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_chk <= 1'b0;
      r_cnt <= 0;
    end else if (check_o) begin
      r_chk <= 1'b1;
      r_cnt <= (long_l2 && lane_o == 2) ? 10 : 1;
    end else if (r_chk && !(stuck_l0 && lane_o == 0)) begin
      if (r_cnt <= 1) r_chk <= 1'b0;
      else r_cnt <= r_cnt - 1;
    end
  end

  assign check_i    = r_chk;
  assign mismatch_i = (sig_o != rfr_o) || (force_mm && lane_o == 2);

  logic [W-1:0] cap_sig [N];
  logic [W-1:0] cap_rfr [N];

  always @(negedge clk) begin
    if (check_o) begin
      cap_sig[lane_o[2:0]] <= sig_o;
      cap_rfr[lane_o[2:0]] <= rfr_o;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 1;
    while (!done_o && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done_o, 1);
  endtask

  function automatic logic [W-1:0] pat(input int k);
    return W'(32'h1 + k * 32'h9E3779B9);
  endfunction

  int   cyc;
  int   hi;
  int   cnt;
  logic seen;
  logic ok;
  logic prev_done;
  logic gap;

  initial begin
    // reset state
    #1;
    chk("rst_lane", lane_o, 0);
    chk("rst_sig", sig_o, 0);
    chk("rst_rfr", rfr_o, 0);
    chk("rst_check", check_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_count_o, 0);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;

    // 1: clean run, timing and patterns
    start_run();
    chk("t1_load_lane", lane_o, 0);
    chk("t1_load_sig", sig_o, 1);
    chk("t1_load_busy", busy_o, 1);
    wait_done(200, cyc);
    chk("t1_cycles", cyc, 33);
    chk("t1_err", err_count_o, 0);
    chk("t1_sig3", cap_sig[3], pat(3));
    chk("t1_rfr3", cap_rfr[3], pat(3));
    chk("t1_sig7", cap_sig[7], pat(7));
    @(negedge clk);
    chk("t1_done_pulse", done_o, 0);
    chk("t1_idle_busy", busy_o, 0);
    chk("t1_err_hold", err_count_o, 0);

    // 2: inject on lane 5
    inject_en_i   = 1'b1;
    inject_lane_i = 4'd5;
    start_run();
    inject_en_i   = 1'b0;
    inject_lane_i = 4'd0;
    wait_done(200, cyc);
    chk("t2_rfr5", cap_rfr[5], cap_sig[5] ^ 32'h1);
    chk("t2_sig5", cap_sig[5], pat(5));
    chk("t2_rfr4", cap_rfr[4], cap_sig[4]);
    chk("t2_err", err_count_o, 1);

    // 2b: out-of-range inject lane corrupts nothing
    inject_en_i   = 1'b1;
    inject_lane_i = 4'd9;
    start_run();
    inject_en_i   = 1'b0;
    wait_done(200, cyc);
    chk("t2b_err", err_count_o, 0);
    chk("t2b_rfr0", cap_rfr[0], pat(0));

    // 3: long check on lane 2 with persistent mismatch
    long_l2  = 1'b1;
    force_mm = 1'b1;
    start_run();
    seen = 1'b0;
    ok   = 1'b0;
    hi   = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (lane_o == 2 && check_i) begin
        seen = 1'b1;
        hi++;
      end else if (seen && lane_o == 2 && !check_i) begin
        chk("t3_err_mid", err_count_o, 1);
        @(negedge clk);
        chk("t3_lane_adv", lane_o, 3);
        ok = 1'b1;
      end
    end
    chk("t3_reached", ok, 1);
    chk("t3_hi_cycles", hi, 10);
    wait_done(200, cyc);
    chk("t3_err", err_count_o, 1);
    long_l2  = 1'b0;
    force_mm = 1'b0;

    // 4: reset in WAIT of lane 4
    start_run();
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (lane_o == 4 && check_i && !check_o) ok = 1'b1;
    end
    chk("t4_reached", ok, 1);
    #1 reset_l = 1'b0;
    #1;
    chk("t4_lane", lane_o, 0);
    chk("t4_sig", sig_o, 0);
    chk("t4_rfr", rfr_o, 0);
    chk("t4_busy", busy_o, 0);
    chk("t4_check", check_o, 0);
    chk("t4_err", err_count_o, 0);
    @(negedge clk);
    reset_l = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done_o || busy_o) seen = 1'b1;
    end
    chk("t4_no_done", seen, 0);
    start_run();
    chk("t4_restart_lane", lane_o, 0);
    chk("t4_restart_sig", sig_o, 1);
    chk("t4_restart_busy", busy_o, 1);
    wait_done(200, cyc);
    chk("t4_cycles", cyc, 33);

    // 5: start held high
    @(negedge clk);
    start_i = 1'b1;
    cnt = 0;
    gap = 1'b0;
    prev_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) cnt++;
      if (prev_done && !busy_o) gap = 1'b1;
      prev_done = done_o;
    end
    chk("t5_one_done", cnt, 1);
    chk("t5_idle_gap", gap, 1);
    start_i = 1'b0;
    wait_done(200, cyc);
    repeat (3) @(negedge clk);
    chk("t5_stays_idle", busy_o, 0);

`ifdef ARR_CHECK_SEQ_TIMEOUT_EN
    // 6: check stuck high on lane 0
    stuck_l0 = 1'b1;
    start_run();
    cyc = 1;
    while (!timeout_o && cyc < 70000) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_timeout", timeout_o, 1);
    chk("t6_cycles", cyc, 65539);
    chk("t6_lane", lane_o, 1);
    chk("t6_err", err_count_o, 1);
    stuck_l0 = 1'b0;
    @(negedge clk);
    chk("t6_pulse", timeout_o, 0);
    wait_done(200, cyc);
    chk("t6_err_done", err_count_o, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
